// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared types and constants for the UART receive frame controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  localparam int EDGE_W = 6;
  localparam int BIT_W  = 4;

  localparam logic [EDGE_W-1:0] c_PRESC_8  = 6'd8;
  localparam logic [EDGE_W-1:0] c_PRESC_16 = 6'd16;
  localparam logic [EDGE_W-1:0] c_PRESC_32 = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // Anything other than the three supported ratios falls back to 8.
  function automatic logic [EDGE_W-1:0] legal_prescale(input logic [EDGE_W-1:0] p);
    if (p == c_PRESC_8 || p == c_PRESC_16 || p == c_PRESC_32)
      return p;
    else
      return c_PRESC_8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : edge_bit_counter
// Purpose  : Per-bit oversampling edge counter and frame data-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              clear,
  input  logic              bit_inc,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              bit_end
);

  assign bit_end = (edge_cnt == (prescale - EDGE_W'(1)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (enable)
        edge_cnt <= bit_end ? '0 : edge_cnt + EDGE_W'(1);
      if (bit_inc)
        bit_cnt <= (bit_cnt == BIT_W'(DATA_WIDTH - 1)) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fsm
// Purpose  : UART receive frame controller: bit timing, checker enables and
//            end-of-frame status strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [EDGE_W-1:0] Prescale,
  input  logic              PAR_EN,
  input  logic              sampled_bit,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic              dat_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              deser_en,
  output logic              strt_chk_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err
);

  rx_state_e         r_state;
  rx_state_e         w_next_state;
  logic [EDGE_W-1:0] r_presc;
  logic              r_par_en;
  logic              r_par_flag;
  logic              w_bit_end;
  logic              w_start_det;
  logic              w_unused;

  // sampled_bit goes straight to the deserializer; frame control never needs it.
  assign w_unused = sampled_bit;

  // The detection cycle is edge 0 of the start bit, so the counter runs then too.
  assign w_start_det = (r_state == S_IDLE) && !RX_IN;

  edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_edge_bit_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   ((r_state != S_IDLE) || w_start_det),
    .clear    ((r_state == S_IDLE) && RX_IN),
    .bit_inc  ((r_state == S_DATA) && w_bit_end),
    .prescale (r_presc),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (w_bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_presc    <= c_PRESC_8;
      r_par_en   <= 1'b0;
      r_par_flag <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start_det) begin
        r_presc  <= legal_prescale(Prescale);
        r_par_en <= PAR_EN;
      end
      if ((r_state == S_PARITY) && w_bit_end)
        r_par_flag <= par_err;
      else if ((r_state == S_STOP) && w_bit_end)
        r_par_flag <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    dat_samp_en  = (r_state != S_IDLE);
    deser_en     = 1'b0;
    strt_chk_en  = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    data_valid   = 1'b0;
    frame_err    = 1'b0;
    parity_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!RX_IN)
          w_next_state = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          strt_chk_en  = 1'b1;
          w_next_state = strt_glitch ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          deser_en = 1'b1;
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1))
            w_next_state = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          par_chk_en   = 1'b1;
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          stp_chk_en   = 1'b1;
          data_valid   = !stp_err && !r_par_flag;
          frame_err    = stp_err;
          parity_err   = r_par_flag;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fsm
// Purpose  : Self-checking bench for uart_rx_fsm against a frame-timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_err, parity_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int frame_no = 0;
  int pvals[6] = '{8, 16, 32, 12, 0, 63};

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK (CLK), .RST (RST), .RX_IN (RX_IN), .Prescale (Prescale), .PAR_EN (PAR_EN),
    .sampled_bit (sampled_bit), .strt_glitch (strt_glitch), .par_err (par_err),
    .stp_err (stp_err), .dat_samp_en (dat_samp_en), .edge_cnt (edge_cnt),
    .bit_cnt (bit_cnt), .deser_en (deser_en), .strt_chk_en (strt_chk_en),
    .par_chk_en (par_chk_en), .stp_chk_en (stp_chk_en), .data_valid (data_valid),
    .frame_err (frame_err), .parity_err (parity_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  // {bit_cnt, edge_cnt, samp, strt, deser, par, stp, valid, frame_err, parity_err}
  function automatic logic [31:0] observed();
    return {14'd0, bit_cnt, edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
            stp_chk_en, data_valid, frame_err, parity_err};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RST = 1'b1; RX_IN = 1'b1;
      Prescale = 6'(pvals[$urandom_range(0, 5)]);
      PAR_EN = 1'($urandom); sampled_bit = 1'($urandom);
      strt_glitch = 1'($urandom); par_err = 1'($urandom); stp_err = 1'($urandom);
      @(negedge CLK);
      check_eq($sformatf("idle after f%0d", frame_no), observed(), 32'd0);
    end
  endtask

  // One frame whose detection cycle is c=0; the model predicts every cycle of it.
  task automatic run_frame(input logic [5:0] presc, input logic pe, input logic [7:0] data,
                           input logic stp_e, input logic par_e, input logic glitch,
                           input int rst_at);
    int p, last, len;
    p    = (presc == 8 || presc == 16 || presc == 32) ? int'(presc) : 8;
    last = glitch ? 0 : 9 + int'(pe);
    len  = (last + 1) * p;
    frame_no++;
    for (int c = 0; c < len; c++) begin
      int b, bc;
      logic be, strt, deser, par, stp;
      logic [31:0] exp;
      b  = c / p;
      be = ((c % p) == p - 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      if (b == 0)                 RX_IN = glitch ? (c >= 3) : 1'b0;
      else if (b <= 8)            RX_IN = data[b-1];
      else if (b == 9 && pe == 1) RX_IN = ^data ^ par_e;
      else                        RX_IN = !stp_e;
      Prescale    = (c == 0) ? presc : 6'(pvals[$urandom_range(0, 5)]);
      PAR_EN      = (c == 0) ? pe : 1'($urandom);
      sampled_bit = 1'($urandom);
      strt_glitch = (be && b == 0) ? glitch : 1'($urandom);
      par_err     = (be && pe && b == 9) ? par_e : 1'($urandom);
      stp_err     = (be && b == last) ? stp_e : 1'($urandom);
      if (c == rst_at) RST = 1'b0;
      @(negedge CLK);
      if (c == rst_at) begin
        check_eq($sformatf("f%0d reset mid-frame", frame_no), observed(), 32'd0);
        return;
      end
      strt  = be && b == 0;
      deser = be && b >= 1 && b <= 8 && !glitch;
      par   = be && pe && b == 9 && !glitch;
      stp   = be && b == last && !glitch;
      bc    = (b >= 1 && b <= 8 && !glitch) ? b - 1 : 0;
      exp = {14'd0, 4'(bc), 6'(c % p), (c != 0), strt, deser, par, stp,
             stp && !stp_e && !(pe && par_e), stp && stp_e, stp && pe && par_e};
      check_eq($sformatf("f%0d P%0d c%0d", frame_no, p, c), observed(), exp);
    end
  endtask

  initial begin
    repeat (2) begin
      @(negedge CLK);
      check_eq("reset", observed(), 32'd0);
    end
    idle(3);
    run_frame(6'd8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1);            // clean frame
    idle(2);
    run_frame(6'd8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, -1);            // start glitch
    run_frame(6'd8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);            // re-arm right after abort
    idle(1);
    run_frame(6'd16, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, -1);           // parity error
    idle(1);
    run_frame(6'd32, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, -1);           // stop error
    run_frame(6'd32, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, -1);           // back-to-back
    idle(1);
    run_frame(6'd8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 5 * 8 + 3);     // reset at data bit 4
    idle(2);
    run_frame(6'd8, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    run_frame(6'd12, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, -1);           // illegal prescale
    for (int f = 0; f < 25; f++) begin
      run_frame(6'(pvals[$urandom_range(0, 5)]), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 60)) : -1);
      idle($urandom_range(0, 3) + (RST ? 0 : 1));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame controller for the UART receiver. It owns the per-bit edge counter and frame bit counter and enables the oversampling `data_sampling` stage, deserializer and start/parity/stop checkers at the right edges. It sits in the UART_RX top beside those blocks and produces the receiver's `data_valid` and error strobes.

## Interface

- `DATA_WIDTH`, 8: data bits per frame.
- `CLK`  in  1: oversampling clock (Prescale × baud).
- `RST`  in  1: asynchronous, active-low reset.
- `RX_IN`  in  1: serial line; idle high.
- `Prescale`  in  6: oversampling ratio; legal values are 8, 16 and 32.
- `PAR_EN`  in  1: a parity bit follows the data bits.
- `sampled_bit`  in  1: majority-voted bit from the sampler; valid when `edge_cnt == Prescale-1`.
- `strt_glitch`, `par_err`, `stp_err`  in  1 each: checker results; valid in the cycle their enable is high.
- `dat_samp_en`  out  1: sampler enable.
- `edge_cnt`  out  6: edge index within the current bit.
- `bit_cnt`  out  4: data-bit index, 0..DATA_WIDTH-1.
- `deser_en`, `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1 each: one-cycle strobes.
- `data_valid`  out  1: one-cycle pulse; the frame was received clean.
- `frame_err`  out  1: one-cycle pulse; stop-bit error.
- `parity_err`  out  1: one-cycle pulse at frame end; parity error.

## Operation

- States: IDLE, START, DATA, PARITY, STOP. One-hot or binary encoding is allowed.
- **Bit end:** the cycle with `edge_cnt == P-1`, where P is the latched prescale.
- **IDLE**
  - `RX_IN == 0` → START.
  - P latches from `Prescale`. An illegal value latches 8.
  - `edge_cnt` and `bit_cnt` are 0 on entry.
- **START** (bit end)
  - `strt_chk_en` is 1.
  - `strt_glitch == 1` → IDLE, with no outputs.
  - Otherwise → DATA.
- **DATA** (bit end)
  - `deser_en` is 1.
  - If `bit_cnt == DATA_WIDTH-1`: → PARITY when `PAR_EN` is 1, else → STOP. `bit_cnt` returns to 0.
  - Otherwise `bit_cnt` increments.
- **PARITY** (bit end)
  - `par_chk_en` is 1.
  - The `par_err` value is latched into an internal flag.
  - → STOP.
- **STOP** (bit end)
  - `stp_chk_en` is 1.
  - `data_valid = !stp_err && !par_flag`.
  - `frame_err = stp_err`.
  - `parity_err = par_flag`.
  - The flag clears. → IDLE.
- **Counters and enable**
  - `edge_cnt` counts 0..P-1 and wraps to 0 while the state is not IDLE. It is held at 0 in IDLE.
  - `dat_samp_en = (state != IDLE)`.
- **Prescale changes:** `PAR_EN` and `Prescale` changes mid-frame are ignored. Both are latched at start detection.
- **Reset**
  - Asserting `RST` at any time, including mid-frame, forces IDLE.
  - All outputs, counters and the parity flag go to 0. The latched P goes to 8.
- **Back-to-back frames:** a start bit may begin in the cycle after STOP exits. No idle gap is required.

## Timing

- All strobes are registered-free decodes of state plus the bit-end condition. Each is high for exactly one cycle.
- **Frame length:** from the first low `RX_IN` sampled in IDLE to `data_valid` is (1 + DATA_WIDTH + PAR_EN + 1) × P cycles, with `data_valid` high in the last of those cycles.
- At P=8 with parity, frame end is cycle 88 after start detection, counting detection as cycle 1.
- `sampled_bit` and the checker inputs are sampled only on bit-end cycles. Values in other cycles are don't-care.
- **Glitch abort:** after a start-glitch abort, IDLE re-arms on the next cycle.

## Structure

- Package `uart_rx_pkg` holds:
  - the state enum;
  - the legal prescale constants 8, 16 and 32;
  - `EDGE_W=6` and `BIT_W=4`.
- One sub-module, `edge_bit_counter`:
  - inputs: enable, latched P, clear and `bit_inc`;
  - outputs: `edge_cnt`, `bit_cnt` and `bit_end`.
- The FSM and strobe decode stay in `uart_rx_fsm`.

## Test plan

- **Clean frame:** P=8, PAR_EN=0, data 0xA5, clean checkers → 8 `deser_en` pulses 8 cycles apart, and `data_valid` at cycle 80 with `frame_err`=0.
- **Start glitch:** low pulse of 3 cycles, `strt_glitch`=1 at edge 7 → return to IDLE; no `deser_en` and no `data_valid`.
- **Parity error:** P=16, PAR_EN=1, `par_err`=1 at the parity bit end → at cycle 176, `parity_err`=1 and `data_valid`=0.
- **Back-to-back with stop error:** two frames at P=32 with `stp_err`=1 on the first → first frame ends with `frame_err` and no `data_valid`; second frame gets `data_valid` exactly 320 cycles after its start.
- **Mid-frame reset:** reset asserted during DATA at bit 4 → all outputs 0 immediately. Then release the reset and send a new frame → normal completion.
- **Prescale change / illegal value:** `Prescale` changed mid-frame from 8 to 16 → bit timing stays at 8. Illegal `Prescale`=12 → the frame runs at P=8.
